// File: rtl/tmds_ddr_serializer_pkg.sv
// ============================================================================
// Module      : tmds_ddr_serializer_pkg
// Description : TMDS control symbols, clock-channel pattern and phase helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tmds_ddr_serializer_pkg;

    localparam int          c_PHASES        = 5;
    localparam logic [2:0]  c_LAST_PHASE    = 3'd4;

    // The four TMDS control-period codes, indexed by {C1,C0}.
    localparam logic [9:0]  c_TMDS_CTRL_00  = 10'b1101010100;
    localparam logic [9:0]  c_TMDS_CTRL_01  = 10'b0010101011;
    localparam logic [9:0]  c_TMDS_CTRL_10  = 10'b0101010100;
    localparam logic [9:0]  c_TMDS_CTRL_11  = 10'b1010101011;

    localparam logic [9:0]  c_TMDS_CLK_PATTERN = 10'b0000011111;

    typedef logic [2:0] phase_t;

    function automatic phase_t next_phase(input phase_t p);
        return (p == c_LAST_PHASE) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_ddr_lane.sv
// ============================================================================
// Module      : tmds_ddr_lane
// Description : One TMDS channel: symbol capture register and 10->2 DDR shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmds_ddr_lane
    import tmds_ddr_serializer_pkg::*;
#(
    parameter logic [9:0] IDLE_SYMBOL = c_TMDS_CTRL_00
) (
    input  logic       clk_x5,
    input  logic       reset,
    input  logic       i_capture,
    input  logic       i_load,
    input  logic [9:0] i_symbol,
    input  logic       i_valid,
    output logic [1:0] o_pair
);

    logic [9:0] r_cap;
    logic [7:0] r_shift;
    logic [1:0] r_pair;

    // Pairs leave LSB first; the even bit sits in [1] for the rising DDR edge.
    always_ff @(posedge clk_x5) begin
        if (reset) begin
            r_cap   <= IDLE_SYMBOL;
            r_shift <= '0;
            r_pair  <= 2'b00;
        end else begin
            if (i_capture) begin
                r_cap <= i_valid ? i_symbol : IDLE_SYMBOL;
            end
            if (i_load) begin
                r_pair  <= {r_cap[0], r_cap[1]};
                r_shift <= r_cap[9:2];
            end else begin
                r_pair  <= {r_shift[0], r_shift[1]};
                r_shift <= r_shift >> 2;
            end
        end
    end

    assign o_pair = r_pair;

endmodule

`default_nettype wire

// File: rtl/tmds_ddr_serializer.sv
// ============================================================================
// Module      : tmds_ddr_serializer
// Description : Pixel-phase sequencer, pclk generator and four DDR TMDS lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmds_ddr_serializer
    import tmds_ddr_serializer_pkg::*;
#(
    parameter logic [9:0] IDLE_SYMBOL   = c_TMDS_CTRL_00,
    parameter logic [9:0] CLK_PATTERN   = c_TMDS_CLK_PATTERN,
    parameter int         CAPTURE_PHASE = 3,
    parameter int         UNDERRUN_W    = 16
) (
    input  logic                  clk_x5,
    input  logic                  reset,
    input  logic [9:0]            in_red,
    input  logic [9:0]            in_green,
    input  logic [9:0]            in_blue,
    input  logic                  in_valid,
    output logic                  pclk,
    output logic [2:0]            phase,
    output logic [1:0]            out_tmds_red,
    output logic [1:0]            out_tmds_green,
    output logic [1:0]            out_tmds_blue,
    output logic [1:0]            out_tmds_clk,
    output logic [UNDERRUN_W-1:0] underrun_cnt,
    output logic                  underrun_sticky
);

    generate
        if (CAPTURE_PHASE < 2 || CAPTURE_PHASE > 4) begin : g_bad_capture_phase
            $error("tmds_ddr_serializer: CAPTURE_PHASE must be in 2..4");
        end
    endgenerate

    phase_t                r_phase;
    logic                  r_pclk;
    logic [UNDERRUN_W-1:0] r_underrun_cnt;
    logic                  r_underrun_sticky;

    phase_t                w_phase_next;
    logic                  w_capture;
    logic                  w_load;

    assign w_phase_next = next_phase(r_phase);
    assign w_capture    = (r_phase == 3'(CAPTURE_PHASE));
    assign w_load       = (r_phase == c_LAST_PHASE);

    // pclk is registered from the next phase so its rise lands on entry to phase 0.
    always_ff @(posedge clk_x5) begin
        if (reset) begin
            r_phase           <= 3'd0;
            r_pclk            <= 1'b0;
            r_underrun_cnt    <= '0;
            r_underrun_sticky <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            r_pclk  <= (w_phase_next < 3'd2);
            if (w_capture && !in_valid) begin
                r_underrun_sticky <= 1'b1;
                if (r_underrun_cnt != '1) begin
                    r_underrun_cnt <= r_underrun_cnt + 1'b1;
                end
            end
        end
    end

    logic [9:0] w_data_sym  [3];
    logic [1:0] w_data_pair [3];

    assign w_data_sym[0] = in_red;
    assign w_data_sym[1] = in_green;
    assign w_data_sym[2] = in_blue;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_data_lane
            tmds_ddr_lane #(
                .IDLE_SYMBOL (IDLE_SYMBOL)
            ) u_lane (
                .clk_x5    (clk_x5),
                .reset     (reset),
                .i_capture (w_capture),
                .i_load    (w_load),
                .i_symbol  (w_data_sym[g]),
                .i_valid   (in_valid),
                .o_pair    (w_data_pair[g])
            );
        end
    endgenerate

    // The clock lane reuses the data lane with its "idle" symbol set to the pattern.
    tmds_ddr_lane #(
        .IDLE_SYMBOL (CLK_PATTERN)
    ) u_clk_lane (
        .clk_x5    (clk_x5),
        .reset     (reset),
        .i_capture (w_capture),
        .i_load    (w_load),
        .i_symbol  (CLK_PATTERN),
        .i_valid   (1'b1),
        .o_pair    (out_tmds_clk)
    );

    assign out_tmds_red    = w_data_pair[0];
    assign out_tmds_green  = w_data_pair[1];
    assign out_tmds_blue   = w_data_pair[2];
    assign pclk            = r_pclk;
    assign phase           = r_phase;
    assign underrun_cnt    = r_underrun_cnt;
    assign underrun_sticky = r_underrun_sticky;

endmodule

`default_nettype wire

// File: tb/tb_tmds_ddr_serializer.sv
// ============================================================================
// Module      : tb_tmds_ddr_serializer
// Description : Randomized self-checking bench against a symbol-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmds_ddr_serializer;

    localparam int         UW    = 4;
    localparam logic [9:0] IDLE  = 10'b1101010100;
    localparam logic [9:0] CLKP  = 10'b0000011111;
    localparam int         CMAX  = (1 << UW) - 1;

    logic          clk_x5 = 1'b0;
    logic          reset  = 1'b1;
    logic [9:0]    in_red = '0, in_green = '0, in_blue = '0;
    logic          in_valid = 1'b1;
    logic          pclk;
    logic [2:0]    phase;
    logic [1:0]    out_tmds_red, out_tmds_green, out_tmds_blue, out_tmds_clk;
    logic [UW-1:0] underrun_cnt;
    logic          underrun_sticky;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_x5 = ~clk_x5;

    tmds_ddr_serializer #(
        .UNDERRUN_W (UW)
    ) dut (
        .clk_x5          (clk_x5),
        .reset           (reset),
        .in_red          (in_red),
        .in_green        (in_green),
        .in_blue         (in_blue),
        .in_valid        (in_valid),
        .pclk            (pclk),
        .phase           (phase),
        .out_tmds_red    (out_tmds_red),
        .out_tmds_green  (out_tmds_green),
        .out_tmds_blue   (out_tmds_blue),
        .out_tmds_clk    (out_tmds_clk),
        .underrun_cnt    (underrun_cnt),
        .underrun_sticky (underrun_sticky)
    );

    // Symbol-level model: a symbol captured at phase 3 goes out as five bit pairs
    // starting after the next phase-4 edge; before any such load the line is 00.
    int         m_phase  = 0;
    logic [9:0] m_cap [3];
    logic [9:0] m_sym [4];
    int         m_idx    = 0;
    bit         m_active = 0;
    int         m_cnt    = 0;
    bit         m_sticky = 0;
    bit         m_pclk   = 0;

    always @(posedge clk_x5) begin
        if (reset) begin
            m_phase  = 0;
            m_cap    = '{IDLE, IDLE, IDLE};
            m_active = 0;
            m_idx    = 0;
            m_cnt    = 0;
            m_sticky = 0;
            m_pclk   = 0;
        end else begin
            if (m_phase == 3) begin
                m_cap[0] = in_valid ? in_red   : IDLE;
                m_cap[1] = in_valid ? in_green : IDLE;
                m_cap[2] = in_valid ? in_blue  : IDLE;
                if (!in_valid) begin
                    if (m_cnt < CMAX) m_cnt = m_cnt + 1;
                    m_sticky = 1;
                end
            end
            if (m_phase == 4) begin
                m_sym[0] = m_cap[0];
                m_sym[1] = m_cap[1];
                m_sym[2] = m_cap[2];
                m_sym[3] = CLKP;
                m_idx    = 0;
                m_active = 1;
            end else if (m_active) begin
                m_idx = m_idx + 1;
            end
            m_phase = (m_phase + 1) % 5;
            m_pclk  = (m_phase < 2);
        end
    end

    function automatic logic [1:0] exp_pair(input int ch);
        logic [9:0] s;
        if (!m_active) return 2'b00;
        s = m_sym[ch];
        return {s[2*m_idx], s[2*m_idx+1]};
    endfunction

    function automatic logic [1:0] dut_pair(input int ch);
        case (ch)
            0:       return out_tmds_red;
            1:       return out_tmds_green;
            2:       return out_tmds_blue;
            default: return out_tmds_clk;
        endcase
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_x5);
            vectors++;
            if (phase !== 3'd0 || pclk !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_phase: got phase=%0d pclk=%b expected phase=0 pclk=0", phase, pclk);
            end
            for (int ch = 0; ch < 4; ch++) begin
                vectors++;
                if (dut_pair(ch) !== 2'b00) begin
                    miscompares++;
                    $display("FAIL reset_pair ch%0d: got %b expected 00", ch, dut_pair(ch));
                end
            end
            vectors++;
            if (underrun_cnt !== '0 || underrun_sticky !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_underrun: got cnt=%0d sticky=%b expected 0/0", underrun_cnt, underrun_sticky);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_clock_pattern();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_x5);
            vectors++;
            if (phase !== 3'(m_phase)) begin
                miscompares++;
                $display("FAIL clk_phase cyc%0d: got %0d expected %0d", c, phase, m_phase);
            end
            vectors++;
            if (pclk !== m_pclk) begin
                miscompares++;
                $display("FAIL clk_pclk cyc%0d: got %b expected %b", c, pclk, m_pclk);
            end
            vectors++;
            if (out_tmds_clk !== exp_pair(3)) begin
                miscompares++;
                $display("FAIL clk_pattern cyc%0d: got %b expected %b", c, out_tmds_clk, exp_pair(3));
            end
        end
    endtask

    task automatic test_red_fixed();
        logic [1:0] want [5];
        want = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b01};
        in_red   = 10'b1010011100;
        in_valid = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk_x5);
            vectors++;
            if (out_tmds_red !== exp_pair(0)) begin
                miscompares++;
                $display("FAIL red_model cyc%0d: got %b expected %b", c, out_tmds_red, exp_pair(0));
            end
            if (c >= 10) begin
                vectors++;
                if (out_tmds_red !== want[m_idx]) begin
                    miscompares++;
                    $display("FAIL red_fixed cyc%0d: got %b expected %b", c, out_tmds_red, want[m_idx]);
                end
            end
        end
    endtask

    task automatic test_underrun();
        int n_low = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk_x5);
        reset = 1'b0;
        for (int c = 0; c < 45; c++) begin
            in_red   = 10'($urandom);
            in_green = 10'($urandom);
            in_blue  = 10'($urandom);
            if (c >= 10 && m_phase == 3 && n_low < 3) begin
                in_valid = 1'b0;
                n_low++;
            end else begin
                in_valid = 1'b1;
            end
            @(negedge clk_x5);
            for (int ch = 0; ch < 3; ch++) begin
                vectors++;
                if (dut_pair(ch) !== exp_pair(ch)) begin
                    miscompares++;
                    $display("FAIL underrun_data ch%0d cyc%0d: got %b expected %b", ch, c, dut_pair(ch), exp_pair(ch));
                end
            end
            vectors++;
            if (underrun_cnt !== UW'(m_cnt) || underrun_sticky !== m_sticky) begin
                miscompares++;
                $display("FAIL underrun_track cyc%0d: got cnt=%0d sticky=%b expected %0d/%b", c, underrun_cnt, underrun_sticky, m_cnt, m_sticky);
            end
        end
        vectors++;
        if (underrun_cnt !== UW'(3) || underrun_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_final: got cnt=%0d sticky=%b expected 3/1", underrun_cnt, underrun_sticky);
        end
    endtask

    task automatic test_glitch();
        logic [9:0] good = 10'($urandom);
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_green = (m_phase == 3) ? good : (~good ^ 10'($urandom_range(0, 15)));
            @(negedge clk_x5);
            vectors++;
            if (out_tmds_green !== exp_pair(1)) begin
                miscompares++;
                $display("FAIL glitch_model cyc%0d: got %b expected %b", c, out_tmds_green, exp_pair(1));
            end
            if (c >= 10) begin
                vectors++;
                if (out_tmds_green !== {good[2*m_idx], good[2*m_idx+1]}) begin
                    miscompares++;
                    $display("FAIL glitch_good cyc%0d: got %b expected %b", c, out_tmds_green, {good[2*m_idx], good[2*m_idx+1]});
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            in_red   = 10'($urandom);
            in_green = 10'($urandom);
            in_blue  = 10'($urandom);
            in_valid = ($urandom_range(0, 4) != 0);
            @(negedge clk_x5);
            for (int ch = 0; ch < 4; ch++) begin
                vectors++;
                if (dut_pair(ch) !== exp_pair(ch)) begin
                    miscompares++;
                    $display("FAIL random_pair ch%0d cyc%0d: got %b expected %b", ch, c, dut_pair(ch), exp_pair(ch));
                end
            end
            vectors++;
            if (phase !== 3'(m_phase) || pclk !== m_pclk || underrun_cnt !== UW'(m_cnt)) begin
                miscompares++;
                $display("FAIL random_ctrl cyc%0d: got ph=%0d pclk=%b cnt=%0d expected %0d/%b/%0d", c, phase, pclk, underrun_cnt, m_phase, m_pclk, m_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (m_phase != 2 && guard < 10) begin
            @(negedge clk_x5);
            guard++;
        end
        vectors++;
        if (m_phase != 2) begin
            miscompares++;
            $display("FAIL reset_mid_wait: got phase %0d expected 2", m_phase);
        end
        reset = 1'b1;
        @(negedge clk_x5);
        for (int ch = 0; ch < 4; ch++) begin
            vectors++;
            if (dut_pair(ch) !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_mid_pair ch%0d: got %b expected 00", ch, dut_pair(ch));
            end
        end
        vectors++;
        if (phase !== 3'd0 || pclk !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_phase: got phase=%0d pclk=%b expected 0/0", phase, pclk);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk_x5);
            for (int ch = 0; ch < 4; ch++) begin
                vectors++;
                if (dut_pair(ch) !== exp_pair(ch)) begin
                    miscompares++;
                    $display("FAIL reset_mid_restart ch%0d cyc%0d: got %b expected %b", ch, c, dut_pair(ch), exp_pair(ch));
                end
            end
            vectors++;
            if (phase !== 3'(m_phase)) begin
                miscompares++;
                $display("FAIL reset_mid_seq cyc%0d: got %0d expected %0d", c, phase, m_phase);
            end
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        repeat (2) @(negedge clk_x5);
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_x5);
            vectors++;
            if (underrun_cnt !== UW'(m_cnt)) begin
                miscompares++;
                $display("FAIL sat_track cyc%0d: got %0d expected %0d", c, underrun_cnt, m_cnt);
            end
        end
        vectors++;
        if (underrun_cnt !== UW'(CMAX) || underrun_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_final: got cnt=%0d sticky=%b expected %0d/1", underrun_cnt, underrun_sticky, CMAX);
        end
        in_valid = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clock_pattern();
        test_red_fixed();
        test_underrun();
        test_glitch();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
